// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC register, imem handshake, next-PC select
// Holds the fetched word for decode and exposes commit/PC+4 to the datapath.
module instruction_fetch #(
  parameter logic [31:0] PC_RESET   = 32'h0040_0000,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  BranchEQ,
  input  logic                  BranchNE,
  input  logic                  Jump,
  input  logic                  Jal,
  input  logic                  JumpRegister,
  input  logic                  Zero,
  input  logic [DATA_WIDTH-1:0] RegJR,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PC_plus4,
  output logic                  instr_valid,
  output logic                  commit,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_misalign;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_br_offset;
  logic [DATA_WIDTH-1:0] w_br_target;
  logic [DATA_WIDTH-1:0] w_jump_target;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic                  w_jr_misalign;
  logic                  w_take_branch;
  logic                  w_load_instr;
  logic                  w_load_pc;
  logic                  w_set_err;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_br_offset   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_target   = w_pc_plus4 + w_br_offset;
  assign w_jump_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
  assign w_take_branch = (BranchEQ & Zero) | (BranchNE & ~Zero);
  assign w_jr_misalign = JumpRegister & (RegJR[1:0] != 2'b00);

  // Jal always comes with Jump from the control unit; either selects the jump target.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (JumpRegister) begin
      w_next_pc = RegJR;
    end else if (Jump | Jal) begin
      w_next_pc = w_jump_target;
    end else if (w_take_branch) begin
      w_next_pc = w_br_target;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_instr = 1'b0;
    w_load_pc    = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (imem_ready) begin
          w_load_instr = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (enable) begin
          if (w_jr_misalign) begin
            w_set_err    = 1'b1;
            w_next_state = S_ERR;
          end else begin
            w_load_pc    = 1'b1;
            w_next_state = S_REQ;
          end
        end
      end
      S_ERR: begin
        w_next_state = S_ERR;
      end
      default: begin
        w_next_state = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= PC_RESET;
      r_instr    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load_instr) begin
        r_instr <= imem_rdata;
      end
      if (w_load_pc) begin
        r_pc <= w_next_pc;
      end
      if (w_set_err) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign imem_req     = (r_state == S_REQ);
  assign imem_addr    = r_pc;
  assign Instruction  = r_instr;
  assign PC           = r_pc;
  assign PC_plus4     = w_pc_plus4;
  assign instr_valid  = (r_state == S_EXEC);
  assign commit       = instr_valid & enable;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        BranchEQ, BranchNE, Jump, Jal, JumpRegister, Zero;
  logic [31:0] RegJR;
  logic [31:0] Instruction, PC, PC_plus4;
  logic        instr_valid, commit, misalign_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;

  instruction_fetch #(.PC_RESET(32'h0040_0000), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .BranchEQ(BranchEQ), .BranchNE(BranchNE), .Jump(Jump), .Jal(Jal),
    .JumpRegister(JumpRegister), .Zero(Zero), .RegJR(RegJR),
    .Instruction(Instruction), .PC(PC), .PC_plus4(PC_plus4),
    .instr_valid(instr_valid), .commit(commit), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] start;
    logic [31:0] rdata;
    int          lat;
    logic        beq, bne, jmp, jal, jr, zero;
    logic [31:0] regjr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    BranchEQ = 0; BranchNE = 0; Jump = 0; Jal = 0; JumpRegister = 0; Zero = 0;
    RegJR = 32'h0;
  endtask

  // DUT is in REQ at a negedge; answer after lat cycles and land in EXEC.
  task automatic fetch(input logic [31:0] data, input int lat);
    logic [31:0] ea;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      ea = 32'h0;
    end else begin
      ea = exp_q.pop_front();
    end
    cur_pc = ea;
    chk("fetch_pc", PC, ea);
    chk("fetch_addr", imem_addr, ea);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_valid_low", {31'b0, instr_valid}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      imem_ready = 0;
      @(negedge clk);
      chk("wait_req_stable", {31'b0, imem_req}, 32'd1);
      chk("wait_addr_stable", imem_addr, ea);
    end
    imem_ready = 1;
    imem_rdata = data;
    @(negedge clk);
    imem_ready = 0;
    imem_rdata = $urandom;
    chk("exec_valid", {31'b0, instr_valid}, 32'd1);
    chk("exec_instr", Instruction, data);
  endtask

  task automatic exec(input logic beq, input logic bne, input logic jmp, input logic jal,
                      input logic jr, input logic zero, input logic [31:0] regjr,
                      input logic [31:0] exp_pc);
    chk("exec_pc_plus4", PC_plus4, cur_pc + 32'd4);
    BranchEQ = beq; BranchNE = bne; Jump = jmp; Jal = jal;
    JumpRegister = jr; Zero = zero; RegJR = regjr;
    enable = 1;
    #1;
    chk("exec_commit", {31'b0, commit}, 32'd1);
    @(negedge clk);
    enable = 0;
    clear_ctrl();
    chk("after_exec_req", {31'b0, imem_req}, 32'd1);
    chk("after_exec_commit", {31'b0, commit}, 32'd0);
    exp_q.push_back(exp_pc);
  endtask

  initial begin
    //           name         start         rdata       lat beq bne jmp jal jr zero regjr        exp_pc
    vecs[0] = '{"beq_taken",  32'h0040_0010, 32'h1000_FFFE, 1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0040_000C};
    vecs[1] = '{"beq_not",    32'h0040_0010, 32'h1000_FFFE, 2, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0014};
    vecs[2] = '{"jal",        32'h0040_0020, 32'h0C10_0010, 1, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0040_0040};
    vecs[3] = '{"bne_taken",  32'h0040_0100, 32'h1400_0004, 3, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0040_0114};
    vecs[4] = '{"bne_not",    32'h0040_0100, 32'h1400_0004, 1, 0, 1, 0, 0, 0, 1, 32'h0, 32'h0040_0104};
    vecs[5] = '{"jr_over_j",  32'h0040_0200, 32'h0800_0000, 1, 0, 0, 1, 0, 1, 0, 32'h0040_0100, 32'h0040_0100};
    vecs[6] = '{"j_over_beq", 32'h1000_0000, 32'h0800_0123, 2, 1, 0, 1, 0, 0, 1, 32'h0, 32'h1000_048C};
    vecs[7] = '{"seq_wrap",   32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0000};
    vecs[8] = '{"br_wrap",    32'h0000_0000, 32'h1000_FFFE, 1, 1, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC};
    vecs[9] = '{"jr_aligned", 32'h0040_0300, 32'h03E0_0008, 1, 0, 0, 0, 0, 1, 0, 32'h0040_0100, 32'h0040_0100};

    reset = 1; enable = 0; imem_ready = 0; imem_rdata = 32'h0;
    clear_ctrl();
    cur_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", PC, 32'h0040_0000);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);
    chk("rst_commit", {31'b0, commit}, 32'd0);
    reset = 0;
    exp_q.push_back(32'h0040_0000);

    // first fetch with immediate ready
    fetch(32'h2008_0005, 1);
    exec(0, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0004);

    // stall in EXEC for 4 cycles, then a single advance
    fetch(32'h0109_5020, 2);
    repeat (4) begin
      @(negedge clk);
      chk("stall_commit", {31'b0, commit}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", PC, 32'h0040_0004);
      chk("stall_instr", Instruction, 32'h0109_5020);
    end
    exec(0, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0008);

    for (int i = 0; i < 10; i++) begin
      fetch(32'h0000_0000, 1);
      exec(0, 0, 0, 0, 1, 0, vecs[i].start, vecs[i].start);
      fetch(vecs[i].rdata, vecs[i].lat);
      chk({vecs[i].name, "_pc"}, PC, vecs[i].start);
      exec(vecs[i].beq, vecs[i].bne, vecs[i].jmp, vecs[i].jal, vecs[i].jr,
           vecs[i].zero, vecs[i].regjr, vecs[i].exp_pc);
    end

    // reset during a stalled fetch; the ready arriving under reset is ignored
    begin
      logic [31:0] ea;
      ea = exp_q.pop_front();
      chk("midwait_addr", imem_addr, ea);
      imem_ready = 0;
      repeat (2) begin
        @(negedge clk);
        chk("midwait_req", {31'b0, imem_req}, 32'd1);
        chk("midwait_addr_stable", imem_addr, ea);
      end
      reset = 1; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("midwait_rst_pc", PC, 32'h0040_0000);
      chk("midwait_rst_instr", Instruction, 32'h0);
      @(negedge clk);
      reset = 0; imem_ready = 0;
      @(negedge clk);
      chk("midwait_post_valid", {31'b0, instr_valid}, 32'd0);
      chk("midwait_post_instr", Instruction, 32'h0);
      chk("midwait_post_pc", PC, 32'h0040_0000);
      exp_q.delete();
      exp_q.push_back(32'h0040_0000);
    end

    // misaligned jr parks the block in ERR
    fetch(32'h0100_0008, 1);
    JumpRegister = 1; RegJR = 32'h0040_0102; enable = 1;
    @(negedge clk);
    clear_ctrl();
    for (int i = 0; i < 4; i++) begin
      enable = (i % 2 == 0);
      imem_ready = 1;
      chk("err_flag", {31'b0, misalign_err}, 32'd1);
      chk("err_req", {31'b0, imem_req}, 32'd0);
      chk("err_valid", {31'b0, instr_valid}, 32'd0);
      chk("err_pc", PC, 32'h0040_0000);
      @(negedge clk);
    end
    imem_ready = 0; enable = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("err_cleared", {31'b0, misalign_err}, 32'd0);
    chk("err_rst_req", {31'b0, imem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the MIPS processor. It owns the program counter, fetches from an instruction memory with a variable-latency req/ready handshake, and holds the fetched word whose bits [31:26] drive the control unit's OP input. It consumes the control unit's branch/jump outputs and the ALU Zero flag to compute the next PC. It also provides the commit qualifier that gates architectural writes and PC+4 for the Jal return address.

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset
DATA_WIDTH, 32, instruction/address width (fixed at 32; other values unsupported)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  stall control; low holds the current instruction in EXEC
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (equals PC)
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
BranchEQ  in  1  from control unit
BranchNE  in  1  from control unit
Jump  in  1  from control unit (also high for Jal)
Jal  in  1  from control unit
JumpRegister  in  1  jr decoded by ALU control
Zero  in  1  ALU zero flag
RegJR  in  32  rs register value for jr
Instruction  out  32  latched instruction (OP = Instruction[31:26])
PC  out  32  current program counter
PC_plus4  out  32  PC + 4 (return address for Jal)
instr_valid  out  1  Instruction is valid (state EXEC)
commit  out  1  instr_valid & enable; gates RegWrite/MemWrite downstream
misalign_err  out  1  sticky jr-misalignment error

Behaviour:
- Reset (async, any state, including mid-WAIT): PC=PC_RESET, Instruction=0 (nop), state=REQ, misalign_err=0. All outputs derive from these values. An in-flight imem_ready is ignored.
- States: REQ, EXEC, ERR.
- REQ: imem_req=1, imem_addr=PC, instr_valid=0. Hold req and addr stable until imem_ready=1. On imem_ready, Instruction<=imem_rdata and go to EXEC. Minimum fetch latency is 1 cycle (ready in the first REQ cycle).
- EXEC: instr_valid=1, imem_req=0. If enable=0, hold all state (Instruction and PC unchanged, commit=0). If enable=1, PC<=next_pc and go to REQ. Exception: jr with RegJR[1:0]!=0 goes to ERR with the PC unchanged.
- ERR: imem_req=0, instr_valid=0, misalign_err=1. The block exits ERR only on reset.
- PC_plus4 = PC+4 modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- next_pc priority, highest first:
  - JumpRegister: RegJR.
  - Jump: {PC_plus4[31:28], Instruction[25:0], 2'b00}.
  - BranchEQ & Zero: PC_plus4 + (sign-extended Instruction[15:0] << 2), modulo 2^32.
  - BranchNE & ~Zero: same branch target.
  - Otherwise: PC_plus4.
- Simultaneous signals resolve by the priority above, e.g. JumpRegister+Jump takes RegJR.
- Jal: next_pc is the jump target. PC_plus4 stays valid throughout EXEC so the datapath can write $ra on commit.
- All control inputs are sampled only in EXEC with enable=1; they are don't-care in other states.
- Throughput: with 1-cycle memory, one instruction every 2 cycles.

Test Plan:
- Reset then imem_ready=1 at once with rdata=32'h2008_0005 (addi) → imem_addr=32'h0040_0000; EXEC next cycle with Instruction=32'h2008_0005; after enable, PC=32'h0040_0004.
- Fetch at 32'h0040_0010 with rdata=32'h1000_FFFE (beq, imm=-2), BranchEQ=1, Zero=1 → PC=32'h0040_000C. Same case with Zero=0 → PC=32'h0040_0014.
- Jal at PC=32'h0040_0020, Instruction[25:0]=26'h010_0010, Jal=Jump=1 → PC_plus4=32'h0040_0024 during EXEC; next PC=32'h0040_0040.
- imem_ready delayed 3 cycles → imem_req and imem_addr stable all 3 cycles. Assert reset in cycle 2 → PC=PC_RESET and Instruction=0; the late ready is ignored.
- In EXEC hold enable=0 for 4 cycles → commit=0, instr_valid=1, PC unchanged. Then enable=1 → single advance, commit high for exactly 1 cycle.
- jr with RegJR=32'h0040_0102 → ERR, misalign_err=1 and sticky, imem_req=0. With RegJR=32'h0040_0100 → PC=32'h0040_0100. PC=32'hFFFF_FFFC sequential → PC=0.
